// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and word-packing helpers used by cp0_unit and its bench.
package cp0_pkg;

    localparam logic [4:0] CP0_REG_SR    = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
    localparam logic [4:0] CP0_REG_EPC   = 5'd14;
    localparam logic [4:0] CP0_REG_PRID  = 5'd15;

    localparam int SR_IM_LO     = 10;
    localparam int SR_IM_HI     = 15;
    localparam int SR_EXL       = 1;
    localparam int SR_IE        = 0;
    localparam int CAUSE_BD     = 31;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam logic [31:0] SR_WMASK           = 32'h0000_FC03;
    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'hBFC0_0380;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc;
    } cause_t;

    function automatic logic [31:0] sr_pack(input sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_HI:SR_IM_LO] = s.im;
        w[SR_EXL]            = s.exl;
        w[SR_IE]             = s.ie;
        return w;
    endfunction

    function automatic logic [31:0] cause_pack(input cause_t c);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD]                   = c.bd;
        w[CAUSE_IP_HI:CAUSE_IP_LO]    = c.ip;
        w[CAUSE_EXC_HI:CAUSE_EXC_LO]  = c.exc;
        return w;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception request logic,
// exception entry recording and eret return for the M stage.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID       = 32'h2025_0001,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    sr_t         sr_q, sr_d;
    cause_t      cause_q, cause_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_wr;

    // Requests are masked by EXL so an entry cannot re-trigger until eret.
    assign int_req = (|(hw_int & sr_q.im)) & sr_q.ie & ~sr_q.exl;
    assign exc_req = (exc_code != 5'd0) & ~sr_q.exl;
    assign req     = int_req | exc_req;

    assign sr_wr   = wdata & SR_WMASK;

    always_comb begin
        sr_d       = sr_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        cause_d.ip = hw_int;
        if (req) begin
            sr_d.exl    = 1'b1;
            cause_d.bd  = bd;
            cause_d.exc = int_req ? EXC_INT : exc_code;
            epc_d       = bd ? (vpc - 32'd4) : vpc;
        end else begin
            if (we && (addr == CP0_REG_SR)) begin
                sr_d.im  = sr_wr[SR_IM_HI:SR_IM_LO];
                sr_d.exl = sr_wr[SR_EXL];
                sr_d.ie  = sr_wr[SR_IE];
            end
            if (we && (addr == CP0_REG_EPC)) begin
                epc_d = wdata;
            end
            // eret wins over a same-cycle SR write to EXL.
            if (eret) begin
                sr_d.exl = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CP0_REG_SR:    rdata = sr_pack(sr_q);
            CP0_REG_CAUSE: rdata = cause_pack(cause_q);
            CP0_REG_EPC:   rdata = epc_q;
            CP0_REG_PRID:  rdata = PRID;
            default:       rdata = '0;
        endcase
    end

    assign epc_out    = epc_q;
    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: driver pushes hand-computed expectations,
// a negedge monitor pops and compares them against req/rdata/epc_out.
module tb_cp0_unit;

    localparam logic [31:0] PRID_V = 32'h2025_0001;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    cp0_unit #(
        .PRID       (PRID_V),
        .HANDLER_PC (32'hBFC0_0380)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .vpc        (vpc),
        .bd         (bd),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .eret       (eret),
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard: {req, rdata, epc_out}
    logic [64:0] exp_q[$];
    string       name_q[$];
    logic        chk_en;
    logic        done;
    int          checks;
    int          failures;

    always @(negedge clk) begin
        logic [64:0] e;
        string       n;
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL no_expect: monitor found empty queue");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (req !== e[64]) begin
                    failures++;
                    $display("FAIL %s.req: got %0b expected %0b", n, req, e[64]);
                end
                checks++;
                if (rdata !== e[63:32]) begin
                    failures++;
                    $display("FAIL %s.rdata: got %08h expected %08h", n, rdata, e[63:32]);
                end
                checks++;
                if (epc_out !== e[31:0]) begin
                    failures++;
                    $display("FAIL %s.epc_out: got %08h expected %08h", n, epc_out, e[31:0]);
                end
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL leftover: got %0d pending expected 0", exp_q.size());
            end
            checks++;
            if (handler_pc !== 32'hBFC0_0380) begin
                failures++;
                $display("FAIL handler_pc: got %08h expected bfc00380", handler_pc);
            end
        end
    end

    // driver tasks
    task automatic set_in(input logic w, input logic [4:0] a, input logic [31:0] wd,
                          input logic [31:0] pc, input logic b, input logic [4:0] ec,
                          input logic [5:0] hi, input logic er);
        we = w; addr = a; wdata = wd; vpc = pc; bd = b;
        exc_code = ec; hw_int = hi; eret = er;
    endtask

    task automatic expect_chk(input string n, input logic r, input logic [31:0] rd,
                              input logic [31:0] ep);
        exp_q.push_back({r, rd, ep});
        name_q.push_back(n);
        chk_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0; done = 1'b0;
        reset = 1'b1;
        set_in(0, 5'd0, 32'h0, 32'h0, 0, 5'd0, 6'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        set_in(0, 5'd12, 0, 0, 0, 0, 0, 0);            expect_chk("rst_sr", 0, 32'h0, 32'h0); tick();
        set_in(0, 5'd15, 0, 0, 0, 0, 0, 0);            expect_chk("prid", 0, PRID_V, 32'h0); tick();
        set_in(1, 5'd12, 32'h401, 0, 0, 0, 0, 0);      expect_chk("sr_wr_pre", 0, 32'h0, 32'h0); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 0, 0);            expect_chk("sr_401", 0, 32'h401, 32'h0); tick();
        // interrupt entry
        set_in(0, 5'd14, 0, 32'h3010, 0, 0, 6'd1, 0);  expect_chk("int_req", 1, 32'h0, 32'h0); tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 6'd1, 0);         expect_chk("int_cause", 0, 32'h400, 32'h3010); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 6'd1, 0);         expect_chk("int_sr_exl", 0, 32'h403, 32'h3010); tick();
        // EXL masks an exception
        set_in(0, 5'd14, 0, 32'h7770, 0, 5'd4, 0, 0);  expect_chk("exl_mask", 0, 32'h3010, 32'h3010); tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 0, 0);            expect_chk("exl_cause", 0, 32'h0, 32'h3010); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 0, 1);            expect_chk("eret_pre", 0, 32'h403, 32'h3010); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 0, 0);            expect_chk("eret_sr", 0, 32'h401, 32'h3010); tick();
        // overflow in delay slot
        set_in(0, 5'd13, 0, 32'h3004, 1, 5'd12, 0, 0); expect_chk("ov_req", 1, 32'h0, 32'h3010); tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 0, 0);            expect_chk("ov_cause", 0, 32'h8000_0030, 32'h3000); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 0, 1);            expect_chk("eret2", 0, 32'h403, 32'h3000); tick();
        // interrupt beats exception
        set_in(0, 5'd13, 0, 32'h4000, 0, 5'd4, 6'd1, 0); expect_chk("prio_req", 1, 32'h8000_0030, 32'h3000); tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 0, 0);            expect_chk("prio_cause", 0, 32'h400, 32'h4000); tick();
        set_in(0, 5'd14, 0, 0, 0, 0, 0, 1);            expect_chk("eret3", 0, 32'h4000, 32'h4000); tick();
        // req suppresses mtc0 EPC
        set_in(1, 5'd14, 32'hDEAD_BEEF, 32'h5008, 1, 5'd5, 0, 0); expect_chk("supp_req", 1, 32'h4000, 32'h4000); tick();
        set_in(0, 5'd14, 0, 0, 0, 0, 0, 0);            expect_chk("supp_epc", 0, 32'h5004, 32'h5004); tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 0, 1);            expect_chk("supp_cause", 0, 32'h8000_0014, 32'h5004); tick();
        // write masking
        set_in(1, 5'd12, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); expect_chk("sr_mask_pre", 0, 32'h401, 32'h5004); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 0, 0);            expect_chk("sr_mask", 0, 32'h0000_FC03, 32'h5004); tick();
        set_in(1, 5'd13, 32'hFFFF_FFFF, 0, 0, 0, 0, 0); expect_chk("cause_wr_pre", 0, 32'h8000_0014, 32'h5004); tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 0, 0);            expect_chk("cause_ro", 0, 32'h8000_0014, 32'h5004); tick();
        // we together with eret
        set_in(1, 5'd12, 32'h403, 0, 0, 0, 0, 1);      expect_chk("we_eret_pre", 0, 32'h0000_FC03, 32'h5004); tick();
        set_in(0, 5'd12, 0, 0, 0, 0, 0, 0);            expect_chk("we_eret", 0, 32'h401, 32'h5004); tick();
        set_in(0, 5'd7, 0, 0, 0, 0, 0, 0);             expect_chk("unmapped", 0, 32'h0, 32'h5004); tick();
        set_in(1, 5'd14, 32'h1234_5678, 0, 0, 0, 0, 0); expect_chk("epc_wr_pre", 0, 32'h5004, 32'h5004); tick();
        set_in(0, 5'd14, 0, 0, 0, 0, 0, 0);            expect_chk("epc_wr", 0, 32'h1234_5678, 32'h1234_5678); tick();
        // async reset while an interrupt request is live
        set_in(0, 5'd12, 0, 32'h6000, 0, 0, 6'd1, 0);  expect_chk("rst_async", 0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        tick();
        set_in(0, 5'd13, 0, 0, 0, 0, 6'd1, 0);         expect_chk("rst_cause", 0, 32'h0, 32'h0); tick();
        set_in(0, 5'd14, 0, 0, 0, 0, 6'd1, 0);         expect_chk("rst_epc", 0, 32'h0, 32'h0); tick();
        set_in(0, 5'd15, 0, 0, 0, 0, 6'd1, 0);         expect_chk("rst_prid", 0, PRID_V, 32'h0); tick();
        reset = 1'b0;
        set_in(0, 5'd12, 0, 0, 0, 0, 6'd1, 0);         expect_chk("post_rst", 0, 32'h0, 32'h0); tick();

        set_in(0, 5'd0, 0, 0, 0, 0, 0, 0);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
